// File: rtl/counter_bus_arbiter.sv
// counter_bus_arbiter: shares one single-port counter peripheral between
// NumReq bus hosts. Grants one request per cycle using round-robin priority.
// Routes the fixed one-cycle device response back to the issuing host, and
// generates write completions locally.
module counter_bus_arbiter #(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0]                      host_req_i,
  output logic [NumReq-1:0]                      host_gnt_o,
  input  logic [NumReq-1:0][AddressWidth-1:0]    host_addr_i,
  input  logic [NumReq-1:0]                      host_we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]     host_be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]       host_wdata_i,
  output logic [NumReq-1:0]                      host_rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]       host_rdata_o,
  output logic [NumReq-1:0]                      host_err_o,
  output logic                                   dev_req_o,
  output logic [AddressWidth-1:0]                dev_addr_o,
  output logic                                   dev_we_o,
  output logic [DataWidth/8-1:0]                 dev_be_o,
  output logic [DataWidth-1:0]                   dev_wdata_o,
  input  logic                                   dev_rvalid_i,
  input  logic [DataWidth-1:0]                   dev_rdata_i,
  input  logic                                   dev_err_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  if (DataWidth != 32) begin : g_bad_data_width
    $error("counter_bus_arbiter: DataWidth must be 32");
  end
  if (NumReq < 2 || NumReq > 8) begin : g_bad_num_req
    $error("counter_bus_arbiter: NumReq must be in 2..8");
  end

  logic [IdxW-1:0] r_rr_q;
  logic            r_resp_vld_q;
  logic [IdxW-1:0] r_resp_owner_q;
  logic            r_resp_we_q;

  logic            w_found;
  logic [IdxW-1:0] w_winner;
  logic [IdxW-1:0] w_cand;

  // The device responds at a fixed one-cycle latency for both reads and
  // writes. Its read-valid strobe therefore carries no extra information.
  logic w_unused_dev_rvalid;
  assign w_unused_dev_rvalid = dev_rvalid_i;

  // Pick the first requesting host, scanning from r_rr_q upward with wrap.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_cand = IdxW'((32'(r_rr_q) + i) % NumReq);
      if (!w_found && host_req_i[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Drive the one-hot grant and forward the winner's request fields to the device.
  always_comb begin
    host_gnt_o  = '0;
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    if (w_found) begin
      host_gnt_o[w_winner] = 1'b1;
      dev_addr_o           = host_addr_i[w_winner];
      dev_we_o             = host_we_i[w_winner];
      dev_be_o             = host_be_i[w_winner];
      dev_wdata_o          = host_wdata_i[w_winner];
    end
  end

  assign dev_req_o = |host_req_i;

  // Advance round-robin priority past the winner, and record who owns the next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_q         <= '0;
      r_resp_vld_q   <= 1'b0;
      r_resp_owner_q <= '0;
      r_resp_we_q    <= 1'b0;
    end else begin
      if (w_found) begin
        r_rr_q <= (w_winner == IdxW'(NumReq - 1)) ? '0 : w_winner + 1'b1;
      end
      r_resp_vld_q   <= dev_req_o;
      r_resp_owner_q <= w_winner;
      r_resp_we_q    <= dev_we_o;
    end
  end

  // Steer the device response to the owning host; everyone else sees zeros.
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    host_rvalid_o[r_resp_owner_q] = r_resp_vld_q;
    host_err_o[r_resp_owner_q]    = r_resp_vld_q & dev_err_i;
    host_rdata_o[r_resp_owner_q]  = r_resp_we_q ? '0 : dev_rdata_i;
  end

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(host_gnt_o));
  a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(host_rvalid_o));

endmodule

// File: tb/tb_counter_bus_arbiter.sv
// Directed bench for counter_bus_arbiter. Instance u_dut2 has two hosts and
// talks to a small counter peripheral model. Instance u_dut3 has three hosts
// and exercises the wrap-around of the priority scan.
module tb_counter_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        h_req;
  logic [1:0]        h_gnt;
  logic [1:0][31:0]  h_addr;
  logic [1:0]        h_we;
  logic [1:0][3:0]   h_be;
  logic [1:0][31:0]  h_wdata;
  logic [1:0]        h_rvalid;
  logic [1:0][31:0]  h_rdata;
  logic [1:0]        h_err;
  logic              d_req;
  logic [31:0]       d_addr;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_wdata;
  logic              m_rvalid;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic              err_force;

  logic [2:0]        g_req;
  logic [2:0]        g_gnt;
  logic [2:0][31:0]  g_addr;
  logic [2:0]        g_we;
  logic [2:0][3:0]   g_be;
  logic [2:0][31:0]  g_wdata;
  logic [2:0]        g_rvalid;
  logic [2:0][31:0]  g_rdata;
  logic [2:0]        g_err;
  logic              g_dreq;
  logic [31:0]       g_daddr;
  logic              g_dwe;
  logic [3:0]        g_dbe;
  logic [31:0]       g_dwdata;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  counter_bus_arbiter #(.NumReq(2), .DataWidth(32), .AddressWidth(32)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(h_req), .host_gnt_o(h_gnt), .host_addr_i(h_addr),
    .host_we_i(h_we), .host_be_i(h_be), .host_wdata_i(h_wdata),
    .host_rvalid_o(h_rvalid), .host_rdata_o(h_rdata), .host_err_o(h_err),
    .dev_req_o(d_req), .dev_addr_o(d_addr), .dev_we_o(d_we), .dev_be_o(d_be),
    .dev_wdata_o(d_wdata), .dev_rvalid_i(m_rvalid), .dev_rdata_i(m_rdata),
    .dev_err_i(m_err | err_force)
  );

  counter_bus_arbiter #(.NumReq(3), .DataWidth(32), .AddressWidth(32)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(g_req), .host_gnt_o(g_gnt), .host_addr_i(g_addr),
    .host_we_i(g_we), .host_be_i(g_be), .host_wdata_i(g_wdata),
    .host_rvalid_o(g_rvalid), .host_rdata_o(g_rdata), .host_err_o(g_err),
    .dev_req_o(g_dreq), .dev_addr_o(g_daddr), .dev_we_o(g_dwe), .dev_be_o(g_dbe),
    .dev_wdata_o(g_dwdata), .dev_rvalid_i(1'b0), .dev_rdata_i(32'h0000_1234),
    .dev_err_i(1'b0)
  );

  // Counter peripheral model. Register 0x40000 reads and post-increments, and
  // a full-word write loads it. Any other address errors. Write and idle
  // cycles put junk on rdata.
  logic [31:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 32'h5; m_rvalid <= 1'b0; m_err <= 1'b0; m_rdata <= '0;
    end else if (d_req) begin
      if (d_addr == 32'h0004_0000) begin
        m_err <= 1'b0;
        if (d_we) begin
          m_rvalid <= 1'b0;
          m_rdata  <= 32'hDEAD_BEEF;
          if (d_be == 4'hF) m_cnt <= d_wdata;
        end else begin
          m_rvalid <= 1'b1;
          m_rdata  <= m_cnt;
          m_cnt    <= m_cnt + 32'd1;
        end
      end else begin
        m_err <= 1'b1; m_rvalid <= !d_we; m_rdata <= '0;
      end
    end else begin
      m_rvalid <= 1'b0; m_err <= 1'b0; m_rdata <= 32'hA5A5_A5A5;
    end
  end

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    h_req = '0;
    g_req = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rvalid", 96'(h_rvalid), 96'h0);
    check_eq("rst_dev_req", 96'(d_req), 96'h0);
    check_eq("rst_gnt", 96'(h_gnt), 96'h0);
    rst_n = 1'b1;
    #1;
  endtask

  logic [2:0] exp3 [7];
  logic [1:0] g2;

  initial begin
    h_req = '0; h_we = '0; h_be = {4'hF, 4'hF}; h_wdata = '0;
    h_addr = {32'h0004_0000, 32'h0004_0000};
    g_req = '0; g_addr = '0; g_we = '0; g_be = '0; g_wdata = '0;
    err_force = 1'b0;

    // 1: single read from host0
    do_reset();
    h_req = 2'b01;
    #1;
    check_eq("t1_gnt", 96'(h_gnt), 96'h1);
    check_eq("t1_dev_addr", 96'(d_addr), 96'h4_0000);
    tick();
    check_eq("t1_rvalid", 96'(h_rvalid), 96'h1);
    check_eq("t1_rdata", 96'(h_rdata), 96'h5);
    check_eq("t1_err", 96'(h_err), 96'h0);
    h_req = 2'b00;

    // 2: simultaneous requests after reset
    do_reset();
    h_req = 2'b11;
    #1;
    check_eq("t2_gnt0", 96'(h_gnt), 96'h1);
    tick();
    check_eq("t2_rvalid0", 96'(h_rvalid), 96'h1);
    check_eq("t2_rdata0", 96'(h_rdata), 96'h5);
    h_req = 2'b10;
    #1;
    check_eq("t2_gnt1", 96'(h_gnt), 96'h2);
    tick();
    check_eq("t2_rvalid1", 96'(h_rvalid), 96'h2);
    check_eq("t2_rdata1", 96'(h_rdata), {32'h0, 32'h6, 32'h0});

    // 3: continuous contention alternates, one response per cycle
    h_req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      g2 = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check_eq("t3_gnt", 96'(h_gnt), 96'(g2));
      tick();
      check_eq("t3_rvalid", 96'(h_rvalid), 96'(g2));
      check_eq("t3_rdata", 96'(h_rdata),
               (k % 2 == 0) ? 96'(32'(7 + k)) : {32'h0, 32'(7 + k), 32'h0});
    end
    h_req = 2'b00;

    // 4: write from host1 completes locally with zero rdata
    h_we[1] = 1'b1; h_wdata[1] = 32'h100; h_req = 2'b10;
    #1;
    check_eq("t4_gnt", 96'(h_gnt), 96'h2);
    check_eq("t4_dev_we", 96'(d_we), 96'h1);
    check_eq("t4_dev_wdata", 96'(d_wdata), 96'h100);
    tick();
    check_eq("t4_rvalid", 96'(h_rvalid), 96'h2);
    check_eq("t4_rdata", 96'(h_rdata), 96'h0);
    check_eq("t4_err", 96'(h_err), 96'h0);
    h_we[1] = 1'b0; h_req = 2'b01;
    #1;
    check_eq("t4_rd_gnt", 96'(h_gnt), 96'h1);
    tick();
    check_eq("t4_rd_rdata", 96'(h_rdata), 96'h100);

    // 5: read of an unmapped register errors
    h_addr[0] = 32'h0004_0004;
    #1;
    check_eq("t5_gnt", 96'(h_gnt), 96'h1);
    tick();
    check_eq("t5_rvalid", 96'(h_rvalid), 96'h1);
    check_eq("t5_err", 96'(h_err), 96'h1);
    check_eq("t5_rdata", 96'(h_rdata), 96'h0);

    // idle cycle: device error with nothing pending is ignored
    h_req = 2'b00; err_force = 1'b1;
    #1;
    check_eq("idle_dev_req", 96'(d_req), 96'h0);
    check_eq("idle_dev_addr", 96'(d_addr), 96'h0);
    tick();
    check_eq("idle_rvalid", 96'(h_rvalid), 96'h0);
    check_eq("idle_err", 96'(h_err), 96'h0);
    err_force = 1'b0;

    // 6: reset with a response in flight drops it and clears priority
    h_addr[0] = 32'h0004_0000; h_req = 2'b01;
    #1;
    check_eq("t6_gnt", 96'(h_gnt), 96'h1);
    tick();
    check_eq("t6_pending", 96'(h_rvalid), 96'h1);
    h_req = 2'b00; rst_n = 1'b0;
    #1;
    check_eq("t6_async_clr", 96'(h_rvalid), 96'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_post_rvalid", 96'(h_rvalid), 96'h0);
    h_req = 2'b11;
    #1;
    check_eq("t6_rr_reset", 96'(h_gnt), 96'h1);
    tick();
    h_req = 2'b00;

    // three hosts: scan wraps past the top host back to host0
    exp3 = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 7; k++) begin
      g_req = (k < 4) ? 3'b101 : 3'b111;
      #1;
      check_eq("n3_gnt", 96'(g_gnt), 96'(exp3[k]));
      tick();
      check_eq("n3_rvalid", 96'(g_rvalid), 96'(exp3[k]));
    end
    g_req = 3'b000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
